// File: rtl/clock_step_ctrl.sv
// Execution-control front end: produces the processor advance enable, either
// every cycle (free-run) or as a burst per debounced button press (step).
module clock_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int STEP_BURST      = 1,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_step,
   input  logic             clk_select,
   output logic             cpu_en,
   output logic             mode_step,
   output logic [CNT_W-1:0] cycle_count
);
   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BURST_W = $clog2(STEP_BURST + 1);

   localparam logic [1:0] HOLD  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] IDLE  = 2'd2;
   localparam logic [1:0] BURST = 2'd3;

   logic [1:0]         meta_reg;
   logic [1:0]         sync_reg;
   logic               step_sync;
   logic               sel_sync;
   logic               btn_db_reg;
   logic               btn_prev_reg;
   logic               press;
   logic [DB_W-1:0]    db_cnt_reg;
   logic [1:0]         state_reg;
   logic [1:0]         state_next;
   logic [1:0]         hold_cnt_reg;
   logic [BURST_W-1:0] burst_cnt_reg;

   // Bit 0 carries the step button, bit 1 the mode switch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= {clk_select, clk_step};
         sync_reg <= meta_reg;
      end
   end

   assign step_sync = sync_reg[0];
   assign sel_sync  = sync_reg[1];

   // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_db_reg   <= 1'b0;
         btn_prev_reg <= 1'b0;
         db_cnt_reg   <= '0;
      end else begin
         btn_prev_reg <= btn_db_reg;
         if (step_sync == btn_db_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_reg <= step_sync;
            db_cnt_reg <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
         end
      end
   end

   assign press = btn_db_reg & ~btn_prev_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         HOLD: begin
            if (hold_cnt_reg == 2'd2) begin
               state_next = sel_sync ? IDLE : RUN;
            end
         end
         RUN: begin
            if (sel_sync) begin
               state_next = IDLE;
            end
         end
         IDLE: begin
            // A mode change outranks a simultaneous press.
            if (!sel_sync) begin
               state_next = RUN;
            end else if (press) begin
               state_next = BURST;
            end
         end
         BURST: begin
            if (burst_cnt_reg == BURST_W'(1)) begin
               state_next = IDLE;
            end
         end
         default: state_next = HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= HOLD;
         hold_cnt_reg  <= '0;
         burst_cnt_reg <= '0;
         cpu_en        <= 1'b0;
         mode_step     <= 1'b0;
         cycle_count   <= '0;
      end else begin
         state_reg   <= state_next;
         cpu_en      <= (state_next == RUN) || (state_next == BURST);
         mode_step   <= (state_next == IDLE) || (state_next == BURST);
         cycle_count <= cycle_count + CNT_W'(cpu_en);
         if ((state_reg == HOLD) && (hold_cnt_reg != 2'd2)) begin
            hold_cnt_reg <= hold_cnt_reg + 2'd1;
         end
         if ((state_reg == IDLE) && (state_next == BURST)) begin
            burst_cnt_reg <= BURST_W'(STEP_BURST);
         end else if (state_reg == BURST) begin
            burst_cnt_reg <= burst_cnt_reg - BURST_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl: table-driven free-run checks, hand-built step and
// burst sequences, and a randomized run against a history-based model.
module tb_clock_step_ctrl;
   localparam int DB   = 4;
   localparam int SB_A = 1;
   localparam int SB_B = 5;
   localparam int CW_A = 32;
   localparam int CW_B = 4;

   logic            clk;
   logic            rst_a, step_a, sel_a, en_a, mode_a;
   logic [CW_A-1:0] cnt_a;
   logic            rst_b, step_b, sel_b, en_b, mode_b;
   logic [CW_B-1:0] cnt_b;
   int              total;
   int              bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   clock_step_ctrl #(.DEBOUNCE_CYCLES(DB), .STEP_BURST(SB_A), .CNT_W(CW_A)) dut_a (
      .clk(clk), .rst(rst_a), .clk_step(step_a), .clk_select(sel_a),
      .cpu_en(en_a), .mode_step(mode_a), .cycle_count(cnt_a));

   clock_step_ctrl #(.DEBOUNCE_CYCLES(DB), .STEP_BURST(SB_B), .CNT_W(CW_B)) dut_b (
      .clk(clk), .rst(rst_b), .clk_step(step_b), .clk_select(sel_b),
      .cpu_en(en_b), .mode_step(mode_b), .cycle_count(cnt_b));

   // Model state: raw input histories (bit i = sample taken i edges ago) plus
   // the observable behaviour, derived from the behavioural rules.
   typedef struct {
      bit [15:0] step_hist;
      bit [2:0]  sel_hist;
      bit        db;
      bit        rose_last;
      int        hold_edges;
      bit        running;
      int        burst_left;
      bit        en;
      bit        mode;
      longint    count;
   } model_t;

   model_t ma, mb;

   typedef struct {
      int edge_no;
      bit sel;
      bit exp_en;
      bit exp_mode;
      int exp_cnt;
   } vec_t;

   vec_t fr_tab [7];

   function automatic model_t model_reset();
      model_t m;
      m.step_hist  = '0;
      m.sel_hist   = '0;
      m.db         = 1'b0;
      m.rose_last  = 1'b0;
      m.hold_edges = 0;
      m.running    = 1'b0;
      m.burst_left = 0;
      m.en         = 1'b0;
      m.mode       = 1'b0;
      m.count      = 0;
      return m;
   endfunction

   function automatic model_t model_edge(model_t m, bit step, bit sel, int sb, int cw);
      model_t n;
      bit     sel_seen;
      bit     all_diff;
      n        = m;
      n.count  = (m.count + (m.en ? 1 : 0)) & ((longint'(1) << cw) - 1);
      sel_seen = m.sel_hist[1];
      if (m.hold_edges < 2) begin
         n.hold_edges = m.hold_edges + 1;
      end else if (m.hold_edges == 2) begin
         n.hold_edges = 3;
         n.running    = !sel_seen;
      end else if (m.burst_left > 0) begin
         n.burst_left = m.burst_left - 1;
      end else if (m.running) begin
         if (sel_seen) n.running = 1'b0;
      end else if (!sel_seen) begin
         n.running = 1'b1;
      end else if (m.rose_last) begin
         n.burst_left = sb;
      end
      // Level accepted once the last DB synchronized samples all disagree.
      all_diff = 1'b1;
      for (int i = 1; i <= DB; i++) begin
         if (m.step_hist[i] == m.db) all_diff = 1'b0;
      end
      n.db        = all_diff ? ~m.db : m.db;
      n.rose_last = all_diff && !m.db;
      n.step_hist = {m.step_hist[14:0], step};
      n.sel_hist  = {m.sel_hist[1:0], sel};
      n.en        = (n.hold_edges == 3) && (n.running || (n.burst_left > 0));
      n.mode      = (n.hold_edges == 3) && !n.running;
      return n;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   function automatic longint dut_en(bit use_b);
      return use_b ? longint'(en_b) : longint'(en_a);
   endfunction

   function automatic longint dut_mode(bit use_b);
      return use_b ? longint'(mode_b) : longint'(mode_a);
   endfunction

   function automatic longint dut_cnt(bit use_b);
      return use_b ? longint'(cnt_b) : longint'(cnt_a);
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst_a) ma = model_reset();
      else       ma = model_edge(ma, step_a, sel_a, SB_A, CW_A);
      if (rst_b) mb = model_reset();
      else       mb = model_edge(mb, step_b, sel_b, SB_B, CW_B);
      #1;
      check("model_a_en",   en_a,   ma.en);
      check("model_a_mode", mode_a, ma.mode);
      check("model_a_cnt",  cnt_a,  ma.count);
      check("model_b_en",   en_b,   mb.en);
      check("model_b_mode", mode_b, mb.mode);
      check("model_b_cnt",  cnt_b,  mb.count);
   endtask

   task automatic assert_reset(input bit use_b);
      if (use_b) begin
         rst_b = 1'b1;
         mb    = model_reset();
      end else begin
         rst_a = 1'b1;
         ma    = model_reset();
      end
      #1;
      check(use_b ? "b_rst_en" : "a_rst_en",     dut_en(use_b),   0);
      check(use_b ? "b_rst_mode" : "a_rst_mode", dut_mode(use_b), 0);
      check(use_b ? "b_rst_cnt" : "a_rst_cnt",   dut_cnt(use_b),  0);
   endtask

   // Caller deasserts rst just before; table edge numbers count from there.
   task automatic run_table(input bit use_b);
      int     e;
      longint mask;
      e    = 0;
      mask = use_b ? longint'(15) : longint'(32'hFFFF_FFFF);
      foreach (fr_tab[k]) begin
         if (use_b) sel_b = fr_tab[k].sel;
         else       sel_a = fr_tab[k].sel;
         while (e < fr_tab[k].edge_no) begin
            tick();
            e++;
         end
         check($sformatf("%s_fr_en_e%0d", use_b ? "b" : "a", e), dut_en(use_b), fr_tab[k].exp_en);
         check($sformatf("%s_fr_mode_e%0d", use_b ? "b" : "a", e), dut_mode(use_b), fr_tab[k].exp_mode);
         check($sformatf("%s_fr_cnt_e%0d", use_b ? "b" : "a", e), dut_cnt(use_b),
               longint'(fr_tab[k].exp_cnt) & mask);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int     first;
      int     pulses;
      int     found;
      longint start_cnt;
      longint prev;
      int     wrap_seen;
      bit [6:0] en_seen;
      bit [6:0] mode_seen;
      bit [6:0] exp_en_pat;
      bit [6:0] exp_mode_pat;
      int     hold_a, hold_b, rst_left_a, rst_left_b;

      total = 0;
      bad   = 0;
      rst_a = 1'b1; rst_b = 1'b1;
      step_a = 1'b0; step_b = 1'b0;
      sel_a = 1'b0; sel_b = 1'b1;
      ma = model_reset();
      mb = model_reset();
      fr_tab[0] = '{edge_no: 1,  sel: 1'b0, exp_en: 1'b0, exp_mode: 1'b0, exp_cnt: 0};
      fr_tab[1] = '{edge_no: 2,  sel: 1'b0, exp_en: 1'b0, exp_mode: 1'b0, exp_cnt: 0};
      fr_tab[2] = '{edge_no: 3,  sel: 1'b0, exp_en: 1'b1, exp_mode: 1'b0, exp_cnt: 0};
      fr_tab[3] = '{edge_no: 4,  sel: 1'b0, exp_en: 1'b1, exp_mode: 1'b0, exp_cnt: 1};
      fr_tab[4] = '{edge_no: 5,  sel: 1'b0, exp_en: 1'b1, exp_mode: 1'b0, exp_cnt: 2};
      fr_tab[5] = '{edge_no: 20, sel: 1'b0, exp_en: 1'b1, exp_mode: 1'b0, exp_cnt: 17};
      fr_tab[6] = '{edge_no: 50, sel: 1'b0, exp_en: 1'b1, exp_mode: 1'b0, exp_cnt: 47};

      tick();
      tick();
      check("a_reset_en", en_a, 0);
      check("a_reset_cnt", cnt_a, 0);

      // Free-run from reset.
      rst_a = 1'b0;
      run_table(1'b0);

      // Single step, held button.
      sel_a = 1'b1;
      assert_reset(1'b0);
      tick();
      tick();
      rst_a = 1'b0;
      repeat (5) tick();
      check("a_idle_mode", mode_a, 1);
      check("a_idle_en", en_a, 0);
      step_a = 1'b1;
      first  = 0;
      pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (en_a && first == 0) first = i;
         if (en_a) pulses++;
      end
      check("a_step_first_edge", first, 7);
      check("a_step_pulses", pulses, 1);
      check("a_step_cnt", cnt_a, 1);
      step_a = 1'b0;
      repeat (12) tick();
      check("a_release_cnt", cnt_a, 1);

      // Bounce rejection, then a genuine hold.
      start_cnt = cnt_a;
      pulses    = 0;
      for (int r = 0; r < 10; r++) begin
         step_a = 1'b1;
         for (int i = 0; i < 3; i++) begin tick(); if (en_a) pulses++; end
         step_a = 1'b0;
         for (int i = 0; i < 3; i++) begin tick(); if (en_a) pulses++; end
      end
      check("a_bounce_pulses", pulses, 0);
      check("a_bounce_cnt", cnt_a, start_cnt);
      step_a = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (en_a) pulses++; end
      check("a_hold_pulses", pulses, 1);
      check("a_hold_cnt", cnt_a, start_cnt + 1);
      step_a = 1'b0;
      repeat (12) tick();

      // Burst of 5 with a mode switch and a re-press landing inside it.
      assert_reset(1'b1);
      tick();
      tick();
      rst_b = 1'b0;
      repeat (5) tick();
      step_b = 1'b1;
      found  = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick();
         if (en_b) found = 1;
      end
      check("b_burst_start", found, 1);
      exp_en_pat   = 7'b1011111;
      exp_mode_pat = 7'b0111111;
      if (found == 1) begin
         sel_b        = 1'b0;
         step_b       = 1'b0;
         en_seen[0]   = en_b;
         mode_seen[0] = mode_b;
         for (int j = 1; j < 7; j++) begin
            if (j == 2) step_b = 1'b1;
            tick();
            en_seen[j]   = en_b;
            mode_seen[j] = mode_b;
            if (j == 5) check("b_burst_cnt", cnt_b, 5);
         end
         check("b_burst_en_pattern", en_seen, exp_en_pat);
         check("b_burst_mode_pattern", mode_seen, exp_mode_pat);
      end

      // Counter wrap at 4 bits, then reset mid-run.
      wrap_seen = 0;
      prev      = cnt_b;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (prev == 15 && cnt_b == 0) wrap_seen = 1;
         prev = cnt_b;
      end
      check("b_wrap_15_to_0", wrap_seen, 1);
      check("b_running_before_reset", en_b, 1);
      step_b = 1'b0;
      assert_reset(1'b1);
      tick();
      rst_b = 1'b0;
      run_table(1'b1);

      // Randomized run on both instances against the model.
      sel_a = 1'b1; sel_b = 1'b1;
      hold_a = 0; hold_b = 0; rst_left_a = 0; rst_left_b = 0;
      for (int n = 0; n < 4000; n++) begin
         tick();
         if (rst_a) begin
            if (rst_left_a == 0) rst_a = 1'b0;
            else rst_left_a--;
         end else if ($urandom_range(0, 1499) == 0) begin
            rst_a = 1'b1;
            rst_left_a = int'($urandom_range(0, 2));
         end
         if (rst_b) begin
            if (rst_left_b == 0) rst_b = 1'b0;
            else rst_left_b--;
         end else if ($urandom_range(0, 1499) == 0) begin
            rst_b = 1'b1;
            rst_left_b = int'($urandom_range(0, 2));
         end
         if (hold_a == 0) begin
            step_a = 1'($urandom_range(0, 1));
            hold_a = int'($urandom_range(1, 12));
         end else hold_a--;
         if (hold_b == 0) begin
            step_b = 1'($urandom_range(0, 1));
            hold_b = int'($urandom_range(1, 12));
         end else hold_b--;
         if ($urandom_range(0, 149) == 0) sel_a = ~sel_a;
         if ($urandom_range(0, 149) == 0) sel_b = ~sel_b;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
